// File: rtl/poly_square_synth_pkg.sv
// Shared types and sizing helpers for the poly_square_synth oscillator bank and mixer.
package poly_synth_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_e;

    function automatic int acc_w(input int sample_w, input int num_voices);
        return sample_w + $clog2(num_voices);
    endfunction

    // Left shift that places a full-scale amplitude just below the sample MSB.
    function automatic int amp_shift(input int sample_w, input int amp_w);
        return sample_w - 1 - amp_w;
    endfunction

endpackage

// File: rtl/poly_square_synth_if.sv
// Sample stream between the synthesiser (master) and the I2S controller (slave).
interface poly_square_synth_if #(
    parameter int SAMPLE_W = 16
) ();
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       sample_valid;
    logic                       sample_ready;
    logic                       overrun;

    modport master (output sample_out, output sample_valid, output overrun, input sample_ready);
    modport slave  (input sample_out, input sample_valid, input overrun, output sample_ready);
endinterface

// File: rtl/poly_square_synth_voice_osc.sv
// voice_osc: one square oscillator holding its active config, phase counter and the
// hi/lo level captured on each sample tick; presents a signed contribution to the mixer.
module voice_osc
    import poly_synth_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int AMP_W    = 12,
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       stg_en,
    input  logic [PERIOD_W-1:0]        stg_period,
    input  logic [PERIOD_W-1:0]        stg_duty,
    input  logic [AMP_W-1:0]           stg_amp,
    output logic signed [SAMPLE_W-1:0] contrib
);
    localparam int S = amp_shift(SAMPLE_W, AMP_W);

    logic                en_q, en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] duty_q, duty_d;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [AMP_W-1:0]    amp_q, amp_d;
    logic                hi_q, hi_d;

    logic [PERIOD_W-1:0]        phase_start;
    logic [PERIOD_W:0]          phase_inc;
    logic signed [SAMPLE_W-1:0] level;

    // The staged config takes effect on the same tick that steps the phase.
    always_comb begin
        en_d        = en_q;
        period_d    = period_q;
        duty_d      = duty_q;
        amp_d       = amp_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        phase_start = (stg_en && !en_q) ? '0 : phase_q;
        phase_inc   = {1'b0, phase_start} + {{PERIOD_W{1'b0}}, 1'b1};
        if (tick) begin
            en_d     = stg_en;
            period_d = stg_period;
            duty_d   = stg_duty;
            amp_d    = stg_amp;
            hi_d     = (stg_duty >= stg_period) || (phase_start < stg_duty);
            phase_d  = (phase_inc >= {1'b0, stg_period}) ? '0 : phase_inc[PERIOD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            period_q <= '0;
            duty_q   <= '0;
            amp_q    <= '0;
            phase_q  <= '0;
            hi_q     <= 1'b0;
        end else begin
            en_q     <= en_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            amp_q    <= amp_d;
            phase_q  <= phase_d;
            hi_q     <= hi_d;
        end
    end

    always_comb begin
        level = $signed({{(SAMPLE_W-AMP_W){1'b0}}, amp_q} << S);
        if (!en_q || (period_q == '0)) begin
            contrib = '0;
        end else if (hi_q) begin
            contrib = level;
        end else begin
            contrib = -level;
        end
    end

endmodule

// File: rtl/poly_square_synth.sv
// poly_square_synth: tick divider, config staging, voice bank and sequential mixer FSM.
// Define POLY_SYNTH_SATURATE_EN to clamp the mix; otherwise the mix is scaled down by clog2(NUM_VOICES).
module poly_square_synth
    import poly_synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PERIOD_W   = 16,
    parameter int AMP_W      = 12,
    parameter int SAMPLE_W   = 16,
    parameter int CLK_HZ     = 50_000_000,
    parameter int SAMPLE_HZ  = 48_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_VOICES-1:0]          cfg_voice_en,
    input  logic [NUM_VOICES*PERIOD_W-1:0] cfg_period,
    input  logic [NUM_VOICES*PERIOD_W-1:0] cfg_duty,
    input  logic [NUM_VOICES*AMP_W-1:0]    cfg_amp,
    input  logic                           cfg_load,
    poly_square_synth_if.master            smp
);
    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ACC_W = acc_w(SAMPLE_W, NUM_VOICES);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

`ifdef POLY_SYNTH_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    function automatic logic signed [SAMPLE_W-1:0] finalize(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) return SAT_MAX[SAMPLE_W-1:0];
        if (a < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
        return SAMPLE_W'(a);
    endfunction
`else
    localparam int MIX_SHIFT = $clog2(NUM_VOICES);

    function automatic logic signed [SAMPLE_W-1:0] finalize(input logic signed [ACC_W-1:0] a);
        return SAMPLE_W'(a >>> MIX_SHIFT);
    endfunction
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    logic [NUM_VOICES-1:0]          stg_en_q, stg_en_d;
    logic [NUM_VOICES*PERIOD_W-1:0] stg_period_q, stg_period_d;
    logic [NUM_VOICES*PERIOD_W-1:0] stg_duty_q, stg_duty_d;
    logic [NUM_VOICES*AMP_W-1:0]    stg_amp_q, stg_amp_d;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       valid_q, valid_d;
    logic                       overrun_q, overrun_d;

    logic signed [SAMPLE_W-1:0] contrib [NUM_VOICES];

    always_comb begin
        tick  = (cnt_q == CNT_W'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_comb begin
        stg_en_d     = stg_en_q;
        stg_period_d = stg_period_q;
        stg_duty_d   = stg_duty_q;
        stg_amp_d    = stg_amp_q;
        if (cfg_load) begin
            stg_en_d     = cfg_voice_en;
            stg_period_d = cfg_period;
            stg_duty_d   = cfg_duty;
            stg_amp_d    = cfg_amp;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_osc #(
            .PERIOD_W (PERIOD_W),
            .AMP_W    (AMP_W),
            .SAMPLE_W (SAMPLE_W)
        ) u_voice (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .stg_en     (stg_en_q[v]),
            .stg_period (stg_period_q[v*PERIOD_W +: PERIOD_W]),
            .stg_duty   (stg_duty_q[v*PERIOD_W +: PERIOD_W]),
            .stg_amp    (stg_amp_q[v*AMP_W +: AMP_W]),
            .contrib    (contrib[v])
        );
    end

    // Ticks only land outside IDLE while a sample is stalled in OUTPUT; those are dropped.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = tick && (state_q != IDLE);
        acc_sum   = acc_q + ACC_W'(contrib[idx_q]);
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            ACCUM: begin
                acc_d = acc_sum;
                if (idx_q == LAST_IDX) begin
                    state_d  = OUTPUT;
                    sample_d = finalize(acc_sum);
                    valid_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            OUTPUT: begin
                if (smp.sample_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            stg_en_q     <= '0;
            stg_period_q <= '0;
            stg_duty_q   <= '0;
            stg_amp_q    <= '0;
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stg_en_q     <= stg_en_d;
            stg_period_q <= stg_period_d;
            stg_duty_q   <= stg_duty_d;
            stg_amp_q    <= stg_amp_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign smp.sample_out   = sample_q;
    assign smp.sample_valid = valid_q;
    assign smp.overrun      = overrun_q;

endmodule

// File: tb/tb_poly_square_synth.sv
// Bench for poly_square_synth: directed scenarios plus random config/ready traffic,
// checked every cycle against a tick-level behavioural model of the synthesiser.
module tb_poly_square_synth;
    localparam int NV = 4, PW = 16, AW = 12, SW = 16;
    localparam int CLK_HZ = 1000, SAMPLE_HZ = 100, DIV = 10, SCALE = 8;

`ifdef POLY_SYNTH_SATURATE_EN
    localparam int LVL_ONE = 32760, LVL_ALL = 32767, LVL_1000 = 8000;
`else
    localparam int LVL_ONE = 8190, LVL_ALL = 32760, LVL_1000 = 2000;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NV-1:0]    cfg_voice_en = '0;
    logic [NV*PW-1:0] cfg_period = '0;
    logic [NV*PW-1:0] cfg_duty = '0;
    logic [NV*AW-1:0] cfg_amp = '0;
    logic             cfg_load = 1'b0;

    poly_square_synth_if #(.SAMPLE_W(SW)) smp ();

    poly_square_synth #(
        .NUM_VOICES (NV), .PERIOD_W (PW), .AMP_W (AW), .SAMPLE_W (SW),
        .CLK_HZ (CLK_HZ), .SAMPLE_HZ (SAMPLE_HZ)
    ) dut (
        .clk (clk), .reset (reset_n),
        .cfg_voice_en (cfg_voice_en), .cfg_period (cfg_period), .cfg_duty (cfg_duty),
        .cfg_amp (cfg_amp), .cfg_load (cfg_load), .smp (smp)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_cnt, m_countdown, m_pending, m_sample, last_dut;
    bit m_busy, m_valid, m_ov;
    int s_en[NV], s_per[NV], s_duty[NV], s_amp[NV];
    int a_en[NV], a_per[NV], a_duty[NV], a_amp[NV], ph[NV];
    int got_q[$];

    function automatic int mix_final(input int sum);
`ifdef POLY_SYNTH_SATURATE_EN
        if (sum > 32767) return 32767;
        if (sum < -32768) return -32768;
        return sum;
`else
        return sum >>> 2;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_countdown = 0; m_pending = 0; m_sample = 0; last_dut = 0;
        m_busy = 0; m_valid = 0; m_ov = 0;
        for (int v = 0; v < NV; v++) begin
            s_en[v] = 0; s_per[v] = 0; s_duty[v] = 0; s_amp[v] = 0;
            a_en[v] = 0; a_per[v] = 0; a_duty[v] = 0; a_amp[v] = 0; ph[v] = 0;
        end
        got_q.delete();
    endtask

    // One clock: advance the model for the edge, then compare the DUT outputs.
    task automatic step();
        bit tk, was_busy, hs, hi;
        int sum, start;
        @(posedge clk);
        tk = (m_cnt == DIV - 1);
        was_busy = m_busy;
        hs = m_valid && (smp.sample_ready === 1'b1);
        m_cnt = tk ? 0 : m_cnt + 1;
        m_ov = tk && was_busy;
        if (m_countdown > 0) begin
            m_countdown--;
            if (m_countdown == 0) begin
                m_valid = 1;
                m_sample = m_pending;
            end
        end
        if (hs) begin
            m_valid = 0;
            m_busy = 0;
            got_q.push_back(last_dut);
        end
        if (tk) begin
            sum = 0;
            for (int v = 0; v < NV; v++) begin
                start = (s_en[v] != 0 && a_en[v] == 0) ? 0 : ph[v];
                a_en[v] = s_en[v]; a_per[v] = s_per[v]; a_duty[v] = s_duty[v]; a_amp[v] = s_amp[v];
                hi = (a_duty[v] >= a_per[v]) || (start < a_duty[v]);
                ph[v] = (start + 1 >= a_per[v]) ? 0 : start + 1;
                if (a_en[v] != 0 && a_per[v] != 0) sum += hi ? a_amp[v] * SCALE : -(a_amp[v] * SCALE);
            end
            if (!was_busy) begin
                m_busy = 1;
                m_countdown = NV;
                m_pending = mix_final(sum);
            end
        end
        if (cfg_load) begin
            for (int v = 0; v < NV; v++) begin
                s_en[v] = int'(cfg_voice_en[v]);
                s_per[v] = int'(cfg_period[v*PW +: PW]);
                s_duty[v] = int'(cfg_duty[v*PW +: PW]);
                s_amp[v] = int'(cfg_amp[v*AW +: AW]);
            end
        end
        #1;
        vectors++;
        if (smp.sample_valid !== m_valid) begin
            miscompares++;
            $display("FAIL sample_valid t=%0t: got %b expected %b", $time, smp.sample_valid, m_valid);
        end
        vectors++;
        if (smp.overrun !== m_ov) begin
            miscompares++;
            $display("FAIL overrun t=%0t: got %b expected %b", $time, smp.overrun, m_ov);
        end
        if (m_valid) begin
            vectors++;
            if (smp.sample_out !== 16'(m_sample)) begin
                miscompares++;
                $display("FAIL sample_out t=%0t: got %0d expected %0d", $time, smp.sample_out, m_sample);
            end
        end
        last_dut = int'(smp.sample_out);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cfg_voice_en = '0; cfg_period = '0; cfg_duty = '0; cfg_amp = '0; cfg_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic set_voice(input int v, input int en, input int per, input int duty, input int amp);
        cfg_voice_en[v] = en[0];
        cfg_period[v*PW +: PW] = per[PW-1:0];
        cfg_duty[v*PW +: PW] = duty[PW-1:0];
        cfg_amp[v*AW +: AW] = amp[AW-1:0];
    endtask

    task automatic pulse_load();
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic check_got(input string name, input int idx, input int exp);
        vectors++;
        if (got_q.size() <= idx) begin
            miscompares++;
            $display("FAIL %s[%0d]: got no sample expected %0d", name, idx, exp);
        end else if (got_q[idx] != exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got_q[idx], exp);
        end
    endtask

    task automatic wait_model_valid(input string name);
        for (int k = 0; k < 100 && !m_valid; k++) step();
        vectors++;
        if (!m_valid) begin
            miscompares++;
            $display("FAIL %s: got no valid expected valid within 100 cycles", name);
        end
    endtask

    task automatic test_reset();
        smp.sample_ready = 1'b1;
        do_reset();
        vectors++;
        if (smp.sample_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", smp.sample_valid); end
        vectors++;
        if (smp.sample_out !== 16'sd0) begin miscompares++; $display("FAIL rst_sample: got %0d expected 0", smp.sample_out); end
        vectors++;
        if (smp.overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun: got %b expected 0", smp.overrun); end
        repeat (DIV + NV + 2) step();
        check_got("rst_silent", 0, 0);
    endtask

    task automatic test_single_voice();
        smp.sample_ready = 1'b1;
        do_reset();
        set_voice(0, 1, 4, 2, 4095);
        pulse_load();
        repeat (9 * DIV) step();
        check_got("single", 0, LVL_ONE);
        check_got("single", 1, LVL_ONE);
        check_got("single", 2, -LVL_ONE);
        check_got("single", 3, -LVL_ONE);
        check_got("single", 4, LVL_ONE);
        check_got("single", 6, -LVL_ONE);
    endtask

    task automatic test_all_high();
        smp.sample_ready = 1'b1;
        do_reset();
        for (int v = 0; v < NV; v++) set_voice(v, 1, 8, 8, 4095);
        pulse_load();
        repeat (4 * DIV) step();
        for (int i = 0; i < 3; i++) check_got("all_high", i, LVL_ALL);
    endtask

    task automatic test_stall();
        int held, ov_cnt;
        smp.sample_ready = 1'b0;
        do_reset();
        set_voice(0, 1, 4, 2, 4095);
        pulse_load();
        wait_model_valid("stall_first_valid");
        held = int'(smp.sample_out);
        ov_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (smp.overrun === 1'b1) ov_cnt++;
            vectors++;
            if (int'(smp.sample_out) != held) begin
                miscompares++;
                $display("FAIL stall_hold: got %0d expected %0d", smp.sample_out, held);
            end
        end
        vectors++;
        if (ov_cnt != 2) begin miscompares++; $display("FAIL stall_overruns: got %0d expected 2", ov_cnt); end
        smp.sample_ready = 1'b1;
        repeat (2 * DIV) step();
        check_got("stall", 0, LVL_ONE);
        check_got("stall", 1, -LVL_ONE);
    endtask

    task automatic test_cfg_during_accum();
        smp.sample_ready = 1'b1;
        do_reset();
        set_voice(0, 1, 4, 2, 4095);
        pulse_load();
        for (int k = 0; k < 50 && m_countdown != NV; k++) step();
        vectors++;
        if (m_countdown != NV) begin miscompares++; $display("FAIL cfg_accum_wait: got %0d expected %0d", m_countdown, NV); end
        set_voice(0, 1, 4, 2, 1000);
        pulse_load();
        repeat (3 * DIV) step();
        check_got("cfg_accum", 0, LVL_ONE);
        check_got("cfg_accum", 1, LVL_1000);
        check_got("cfg_accum", 2, -LVL_1000);
    endtask

    task automatic test_edge_cases();
        smp.sample_ready = 1'b1;
        do_reset();
        set_voice(0, 1, 0, 3, 4095);
        set_voice(1, 1, 5, 9, 4095);
        set_voice(2, 0, 6, 2, 4095);
        pulse_load();
        repeat (4 * DIV) step();
        for (int i = 0; i < 3; i++) check_got("edge", i, LVL_ONE);
    endtask

    task automatic test_random();
        smp.sample_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) begin
                for (int v = 0; v < NV; v++)
                    set_voice(v, int'($urandom_range(1)), int'($urandom_range(12)),
                              int'($urandom_range(14)), int'($urandom_range(4095)));
                cfg_load = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            smp.sample_ready = ($urandom_range(3) != 0);
            step();
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_reset_mid_output();
        int first;
        smp.sample_ready = 1'b0;
        do_reset();
        set_voice(0, 1, 4, 2, 4095);
        pulse_load();
        wait_model_valid("midrst_valid");
        step();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (smp.sample_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b expected 0", smp.sample_valid); end
        vectors++;
        if (smp.sample_out !== 16'sd0) begin miscompares++; $display("FAIL midrst_sample: got %0d expected 0", smp.sample_out); end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        smp.sample_ready = 1'b1;
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (first < 0 && smp.sample_valid === 1'b1) first = k;
        end
        vectors++;
        if (first != DIV + NV) begin miscompares++; $display("FAIL midrst_first_valid: got cycle %0d expected %0d", first, DIV + NV); end
        check_got("midrst_silent", 0, 0);
    endtask

    initial begin
        smp.sample_ready = 1'b0;
        test_reset();
        test_single_voice();
        test_all_high();
        test_stall();
        test_cfg_during_accum();
        test_edge_cases();
        test_random();
        test_reset_mid_output();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
